// File: rtl/load_store_unit.sv
// RV32I load/store unit between a CPU request port and a single-port word memory.
// Sub-word stores read the word, merge the new lane(s), then write the merged word back.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] mem_read_data
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;
    logic [31:0] word_reg;

    // Request decode on the live CPU inputs, used only at the accept edge.
    logic funct3_legal;
    logic store_legal;
    logic req_is_half;
    logic req_is_word;
    logic range_err;
    logic req_err;
    logic accept;

    always_comb begin
        funct3_legal = (cpu_funct3 == F3_B) || (cpu_funct3 == F3_H) || (cpu_funct3 == F3_W) ||
                       (cpu_funct3 == F3_BU) || (cpu_funct3 == F3_HU);
        store_legal  = (cpu_funct3 == F3_B) || (cpu_funct3 == F3_H) || (cpu_funct3 == F3_W);
        req_is_half  = (cpu_funct3[1:0] == 2'b01);
        req_is_word  = (cpu_funct3 == F3_W);
        range_err    = ({1'b0, cpu_addr} >= ADDR_LIMIT);
        req_err      = !funct3_legal
                     || (cpu_we && !store_legal)
                     || (req_is_half && cpu_addr[0])
                     || (req_is_word && (cpu_addr[1:0] != 2'b00))
                     || range_err;
        accept       = (state_reg == IDLE) && cpu_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
            word_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= cpu_we;
                funct3_reg <= cpu_funct3;
                addr_reg   <= cpu_addr;
                wdata_reg  <= cpu_wdata;
                err_reg    <= req_err;
            end
            if (state_reg == RD) begin
                word_reg <= mem_read_data;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (req_err) begin
                        state_next = RESP;
                    end else if (!cpu_we) begin
                        state_next = RD;
                    end else if (cpu_funct3 == F3_W) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = we_reg ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read-modify-write merge: each byte lane takes new data only when addressed.
    logic        lat_is_half;
    logic [31:0] merged_word;
    logic [3:0]  lane_sel;

    assign lat_is_half = (funct3_reg[1:0] == 2'b01);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_sel[gi] = lat_is_half ? (addr_reg[1] == 1'(gi / 2))
                                              : (addr_reg[1:0] == 2'(gi));
            assign merged_word[8*gi +: 8] =
                !lane_sel[gi] ? word_reg[8*gi +: 8] :
                lat_is_half   ? wdata_reg[8*(gi % 2) +: 8] :
                                wdata_reg[7:0];
        end
    endgenerate

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_fmt;

    always_comb begin
        case (addr_reg[1:0])
            2'b00:   load_byte = word_reg[7:0];
            2'b01:   load_byte = word_reg[15:8];
            2'b10:   load_byte = word_reg[23:16];
            default: load_byte = word_reg[31:24];
        endcase
        load_half = addr_reg[1] ? word_reg[31:16] : word_reg[15:0];
        case (funct3_reg)
            F3_B:    load_fmt = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_fmt = {24'd0, load_byte};
            F3_H:    load_fmt = {{16{load_half[15]}}, load_half};
            F3_HU:   load_fmt = {16'd0, load_half};
            F3_W:    load_fmt = word_reg;
            default: load_fmt = 32'd0;
        endcase
    end

    // All outputs decode from registered state so reset clears them without a clock.
    always_comb begin
        cpu_busy       = (state_reg != IDLE);
        cpu_done       = 1'b0;
        cpu_err        = 1'b0;
        cpu_rdata      = 32'd0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        mem_write_data = 32'd0;
        mem_addr       = {addr_reg[31:2], 2'b00};
        case (state_reg)
            RD: MemRead = 1'b1;
            WR: begin
                MemWrite       = 1'b1;
                mem_write_data = (funct3_reg == F3_W) ? wdata_reg : merged_word;
            end
            RESP: begin
                cpu_done = 1'b1;
                cpu_err  = err_reg;
                if (!we_reg && !err_reg) begin
                    cpu_rdata = load_fmt;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor checks each cpu_done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, synchronous write, plus a backdoor preload port.
    logic [31:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'd0;
    logic [31:0] bd_data = 32'd0;

    assign mem_read_data = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (MemWrite) mem[mem_addr[9:2]] <= mem_write_data;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rds;
        int          wrs;
        int          req_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts memory strobes per operation and checks each completion.
    always @(negedge clk) begin
        if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (MemRead && MemWrite) begin
                checks++;
                failures++;
                $display("FAIL mem_excl: MemRead and MemWrite both 1 at cycle %0d", cyc);
            end
            if (MemRead) rd_cnt++;
            if (MemWrite) wr_cnt++;
            if (cpu_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("rdata", cpu_rdata, mon_e.rdata);
                    check("err", 32'(cpu_err), 32'(mon_e.err));
                    check("latency", 32'(cyc - mon_e.req_cyc), 32'(mon_e.lat));
                    check("mem_reads", 32'(rd_cnt), 32'(mon_e.rds));
                    check("mem_writes", 32'(wr_cnt), 32'(mon_e.wrs));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic poke(input int idx, input logic [31:0] data);
        bd_we = 1'b1;
        bd_addr = 8'(idx);
        bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat, input int rds, input int wrs);
        exp_t e;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.lat = lat;
        e.rds = rds;
        e.wrs = wrs;
        e.req_cyc = cyc;
        sb.push_back(e);
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_funct3 = f3;
        cpu_addr = addr;
        cpu_wdata = wdata;
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!cpu_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done within 20 cycles, expected done");
        end
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int lat, input int rds, input int wrs);
        issue(we, f3, addr, wdata, exp_rdata, exp_err, lat, rds, wrs);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_funct3 = 3'b000;
        cpu_addr = 32'd0;
        cpu_wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(cpu_busy), 32'd0);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_err", 32'(cpu_err), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // SW then LW
        op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
        check("mem_sw", mem[4], 32'hDEADBEEF);
        op(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

        // Byte merge and byte loads
        poke(4, 32'h11223344);
        op(1'b1, 3'b000, 32'h12, 32'h000000AA, 32'h0, 1'b0, 3, 1, 1);
        check("mem_sb", mem[4], 32'h11AA3344);
        op(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
        op(1'b0, 3'b100, 32'h12, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0);
        op(1'b0, 3'b000, 32'h10, 32'h0, 32'h00000044, 1'b0, 2, 1, 0);

        // Halfword merge and loads, then a top-lane byte store
        poke(8, 32'h00000000);
        op(1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0, 1'b0, 3, 1, 1);
        check("mem_sh", mem[8], 32'h80010000);
        op(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 2, 1, 0);
        op(1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0, 2, 1, 0);
        op(1'b1, 3'b000, 32'h23, 32'h0000007F, 32'h0, 1'b0, 3, 1, 1);
        check("mem_sb_top", mem[8], 32'h7F010000);
        op(1'b0, 3'b000, 32'h23, 32'h0, 32'h0000007F, 1'b0, 2, 1, 0);
        op(1'b0, 3'b100, 32'h22, 32'h0, 32'h00000001, 1'b0, 2, 1, 0);
        op(1'b0, 3'b001, 32'h20, 32'h0, 32'h00000000, 1'b0, 2, 1, 0);
        op(1'b0, 3'b010, 32'h20, 32'h0, 32'h7F010000, 1'b0, 2, 1, 0);

        // Error requests: no memory strobes, done after one cycle
        op(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        op(1'b1, 3'b001, 32'h21, 32'h5555, 32'h0, 1'b1, 1, 0, 0);
        op(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        op(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        op(1'b1, 3'b100, 32'h0, 32'h12, 32'h0, 1'b1, 1, 0, 0);
        op(1'b0, 3'b101, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        check("mem_after_err", mem[8], 32'h7F010000);

        // Last in-range word
        poke(255, 32'hCAFEF00D);
        op(1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0);

        // Request during RD is ignored
        poke(16, 32'h00000000);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h11AA3344, 1'b0, 2, 1, 0);
        check("busy_in_rd", 32'(cpu_busy), 32'd1);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_funct3 = 3'b010;
        cpu_addr = 32'h40;
        cpu_wdata = 32'h12345678;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_done();
        @(negedge clk);
        check("idle_after_resp", 32'(cpu_busy), 32'd0);
        @(negedge clk);
        check("ignored_not_accepted", 32'(cpu_busy), 32'd0);
        check("mem_ignored_sw", mem[16], 32'h00000000);

        // Reset during WR of an SB
        poke(12, 32'h55667788);
        issue(1'b1, 3'b000, 32'h31, 32'h000000EE, 32'h0, 1'b0, 3, 1, 1);
        @(negedge clk);
        check("wr_strobe", 32'(MemWrite), 32'd1);
        check("wr_addr", mem_addr, 32'h30);
        reset = 1'b1;
        #1;
        check("arst_memwrite", 32'(MemWrite), 32'd0);
        check("arst_busy", 32'(cpu_busy), 32'd0);
        check("arst_done", 32'(cpu_done), 32'd0);
        check("arst_err", 32'(cpu_err), 32'd0);
        check("arst_rdata", cpu_rdata, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mem_after_abort", mem[12], 32'h55667788);
        op(1'b0, 3'b010, 32'h30, 32'h0, 32'h55667788, 1'b0, 2, 1, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
